// File: rtl/dds_ctrl_pkg.sv
// Shared widths, command record and scheduler state encoding for the DDS
// parameter scheduler and its command FIFO.
package dds_ctrl_pkg;

    localparam int TS_W    = 48;
    localparam int FREQ_W  = 48;
    localparam int PHASE_W = 14;

    typedef struct packed {
        logic [TS_W-1:0]    fire_time;
        logic [FREQ_W-1:0]  freq;
        logic [PHASE_W-1:0] phase;
        logic               sync;
    } dds_cmd_t;

    typedef enum logic {
        IDLE = 1'b0,
        ARM  = 1'b1
    } sched_state_t;

endpackage

// File: rtl/param_fifo.sv
// Synchronous command FIFO with a show-ahead head entry, so the scheduler can
// load its staging register on the same edge it pops.
module param_fifo
    import dds_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push_i,
    input  dds_cmd_t                   data_i,
    input  logic                       pop_i,
    output dds_cmd_t                   head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    dds_cmd_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    // Storage carries no reset; validity is tracked entirely by count_q.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/dds_param_scheduler.sv
// Timed command source for the DAC phase MAC: owns the timestamp counter and
// applies queued freq/phase/offset commands when their fire time is reached.
module dds_param_scheduler
    import dds_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [TS_W-1:0]        s_time,
    input  logic [FREQ_W-1:0]      s_freq,
    input  logic [PHASE_W-1:0]     s_phase,
    input  logic                   s_sync,
    output logic [TS_W-1:0]        timestamp,
    output logic [FREQ_W-1:0]      freq,
    output logic [PHASE_W-1:0]     phase,
    output logic [TS_W-1:0]        time_offset,
    output logic                   update,
    output logic                   late_error,
    output logic [$clog2(DEPTH):0] fifo_count
);

    sched_state_t        state_q;
    dds_cmd_t            stg_q;
    dds_cmd_t            head;
    dds_cmd_t            in_cmd;
    logic [TS_W-1:0]     ts_q;
    logic [FREQ_W-1:0]   freq_q;
    logic [PHASE_W-1:0]  phase_q;
    logic [TS_W-1:0]     offset_q;
    logic                update_q;
    logic                late_q;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push_d;
    logic                pop_d;
    logic                apply_d;

    assign in_cmd = '{fire_time: s_time, freq: s_freq, phase: s_phase, sync: s_sync};

    // Holding s_ready low during reset keeps the upstream from believing a
    // command was taken while the FIFO is being cleared.
    assign s_ready = !fifo_full && !reset;
    assign push_d  = s_valid && s_ready;
    assign apply_d = (state_q == ARM) && (stg_q.fire_time <= ts_q);
    assign pop_d   = !fifo_empty && ((state_q == IDLE) || apply_d);

    param_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .srst    (reset),
        .push_i  (push_d),
        .data_i  (in_cmd),
        .pop_i   (pop_d),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            stg_q    <= '0;
            ts_q     <= '0;
            freq_q   <= '0;
            phase_q  <= '0;
            offset_q <= '0;
            update_q <= 1'b0;
            late_q   <= 1'b0;
        end else begin
            ts_q     <= ts_q + 1'b1;
            update_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        stg_q   <= head;
                        state_q <= ARM;
                    end
                end
                ARM: begin
                    if (apply_d) begin
                        freq_q   <= stg_q.freq;
                        phase_q  <= stg_q.phase;
                        update_q <= 1'b1;
                        if (stg_q.sync) begin
                            offset_q <= stg_q.fire_time;
                        end
                        // Plain unsigned compare: a fire time behind the counter is late.
                        if (stg_q.fire_time < ts_q) begin
                            late_q <= 1'b1;
                        end
                        if (!fifo_empty) begin
                            stg_q <= head;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign timestamp   = ts_q;
    assign freq        = freq_q;
    assign phase       = phase_q;
    assign time_offset = offset_q;
    assign update      = update_q;
    assign late_error  = late_q;

endmodule

// File: tb/tb_dds_param_scheduler.sv
// Directed plus randomized bench for dds_param_scheduler; each command's apply
// edge is predicted in closed form from its accept edge and fire time.
module tb_dds_param_scheduler;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [47:0]  s_time;
    logic [47:0]  s_freq;
    logic [13:0]  s_phase;
    logic         s_sync;
    logic [47:0]  timestamp;
    logic [47:0]  freq;
    logic [13:0]  phase;
    logic [47:0]  time_offset;
    logic         update;
    logic         late_error;
    logic [2:0]   fifo_count;

    dds_param_scheduler #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_time      (s_time),
        .s_freq      (s_freq),
        .s_phase     (s_phase),
        .s_sync      (s_sync),
        .timestamp   (timestamp),
        .freq        (freq),
        .phase       (phase),
        .time_offset (time_offset),
        .update      (update),
        .late_error  (late_error),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    // Reference record: a = accept edge, s = edge loaded into staging,
    // p = apply edge.  Edge e is the e-th rising edge after reset release;
    // the timestamp seen just after edge e equals e.
    typedef struct {
        longint      a;
        longint      s;
        longint      p;
        longint      ft;
        logic [47:0] fr;
        logic [13:0] ph;
        bit          sy;
        bit          late;
    } mcmd_t;

    mcmd_t  mq[$];
    longint e = 0;
    int     n_cmp = 0;
    int     n_err = 0;
    bit     accepted;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h at ts=%0d", tag, obs, exp, e);
        end
    endtask

    function automatic int model_count(input longint ee);
        int c;
        c = 0;
        foreach (mq[i]) if (mq[i].a <= ee && mq[i].s > ee) c++;
        return c;
    endfunction

    function automatic longint lmax(input longint x, input longint y);
        return (x > y) ? x : y;
    endfunction

    task automatic add_cmd(input longint a);
        mcmd_t  c;
        longint prev_p;
        prev_p = (mq.size() > 0) ? mq[mq.size()-1].p : 0;
        c.a    = a;
        c.s    = lmax(a + 1, prev_p);
        c.p    = lmax(c.s + 1, longint'(s_time) + 1);
        c.ft   = longint'(s_time);
        c.fr   = s_freq;
        c.ph   = s_phase;
        c.sy   = s_sync;
        c.late = (c.p - 1) > c.ft;
        mq.push_back(c);
    endtask

    task automatic check_outputs();
        logic [47:0] efr;
        logic [13:0] eph;
        logic [47:0] eoff;
        bit          eupd;
        bit          elate;
        efr = '0; eph = '0; eoff = '0; eupd = 1'b0; elate = 1'b0;
        foreach (mq[i]) begin
            if (mq[i].p <= e) begin
                efr = mq[i].fr;
                eph = mq[i].ph;
                if (mq[i].sy) eoff = mq[i].ft[47:0];
                if (mq[i].late) elate = 1'b1;
            end
            if (mq[i].p == e) eupd = 1'b1;
        end
        chk("timestamp", 64'(timestamp), 64'(e[47:0]));
        chk("freq", 64'(freq), 64'(efr));
        chk("phase", 64'(phase), 64'(eph));
        chk("time_offset", 64'(time_offset), 64'(eoff));
        chk("update", 64'(update), 64'(eupd));
        chk("late_error", 64'(late_error), 64'(elate));
        chk("fifo_count", 64'(fifo_count), 64'(model_count(e)));
        $display("ts=%0d upd=%0b freq=%0h phase=%0h off=%0d late=%0b cnt=%0d rdy=%0b",
                 timestamp, update, freq, phase, time_offset, late_error, fifo_count, s_ready);
    endtask

    task automatic cycle();
        bit exp_ready;
        #1;
        exp_ready = !rst && (model_count(e) < DEPTH);
        chk("s_ready", 64'(s_ready), 64'(exp_ready));
        accepted = s_valid && exp_ready;
        if (accepted) add_cmd(e + 1);
        @(posedge clk);
        if (rst) begin
            e = 0;
            mq.delete();
        end else begin
            e++;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic offer(input longint ft, input logic [47:0] fr, input logic [13:0] ph, input bit sy);
        s_valid  = 1'b1;
        s_time   = ft[47:0];
        s_freq   = fr;
        s_phase  = ph;
        s_sync   = sy;
        accepted = 1'b0;
        for (int i = 0; i < 500 && !accepted; i++) cycle();
        if (!accepted) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout observed=not_accepted expected=accepted ft=%0d", ft);
        end
    endtask

    task automatic run_until(input longint target);
        for (int i = 0; i < 5000 && e < target; i++) cycle();
    endtask

    task automatic drain();
        bit busy;
        busy = 1'b1;
        for (int i = 0; i < 3000 && busy; i++) begin
            busy = 1'b0;
            foreach (mq[j]) if (mq[j].p > e) busy = 1'b1;
            if (busy) cycle();
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout observed=pending expected=all_applied");
        end
    endtask

    initial begin
        logic [47:0] rf;
        longint      ft;
        rst = 1'b1; s_valid = 1'b0; s_time = '0; s_freq = '0; s_phase = '0; s_sync = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) cycle();
        rst = 1'b0;

        // Basic on-time apply with sync.
        offer(100, 48'h1000, 14'h3FF, 1'b1);
        s_valid = 1'b0;
        run_until(101);
        chk("t1_freq", 64'(freq), 64'h1000);
        chk("t1_offset", 64'(time_offset), 64'd100);
        run_until(110);

        // sync=0 keeps the previous offset.
        offer(e + 5, 48'hABCDE, 14'h0123, 1'b0);
        s_valid = 1'b0;
        drain();
        chk("t2_offset_kept", 64'(time_offset), 64'd100);

        // Equal fire times: second one lands an edge later and is late.
        offer(200, 48'd1, 14'd5, 1'b0);
        offer(200, 48'd2, 14'd6, 1'b0);
        s_valid = 1'b0;
        run_until(205);
        chk("t3_freq", 64'(freq), 64'd2);
        chk("t3_late", 64'(late_error), 64'd1);

        // Reset, then fill: one staged plus DEPTH queued, sixth offer stalls.
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) offer(e + 40 + k, 48'(k + 16), 14'(k), k[0]);
        s_valid = 1'b0;
        drain();

        // Late command is applied two edges after acceptance.
        run_until(e + 5);
        offer(10, 48'h777, 14'h11, 1'b1);
        s_valid = 1'b0;
        cycle(); cycle();
        chk("t5_freq", 64'(freq), 64'h777);
        chk("t5_late", 64'(late_error), 64'd1);

        // Randomized commands from a fresh reset.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            rf = {16'($urandom), $urandom};
            ft = e + longint'($urandom_range(0, 14)) - 4;
            if (ft < 0) ft = 0;
            offer(ft, rf, 14'($urandom), 1'($urandom));
            s_valid = 1'b0;
            for (int g = $urandom_range(0, 3); g > 0; g--) cycle();
        end
        drain();

        // Reset while three commands sit in the FIFO behind a staged one.
        for (int k = 0; k < 4; k++) offer(e + 20, 48'(k + 3), 14'(k), 1'b1);
        s_valid = 1'b0;
        chk("t7_count_before", 64'(fifo_count), 64'd3);
        rst = 1'b1;
        cycle(); cycle();
        chk("t7_count_reset", 64'(fifo_count), 64'd0);
        chk("t7_freq_reset", 64'(freq), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
